// File: rtl/fetch_sequencer.sv
// NanoQuarter instruction-fetch sequencer: owns the PC, fetches 32-bit words over req/ack
// and presents two 16-bit instructions per word. Define FETCH_PREFETCH_EN for a one-deep prefetch word.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT, REQ_DROP} req_state_t;

    localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

    req_state_t  state;
    logic [31:0] fetch_addr;
    logic [31:0] cur_data;
    logic [29:0] cur_word;
    logic        cur_valid;   // cur word still holds an unpresented slot
    logic        cur_slot;    // next slot of cur word to present
    logic        skip;        // first word after a branch to an upper half: drop slot 0

`ifdef FETCH_PREFETCH_EN
    logic [31:0] pf_data;
    logic [29:0] pf_word;
    logic        pf_valid;
`else
    logic        pf_valid;
    assign pf_valid = 1'b0;
`endif

    logic        ack_data;
    logic        advance;
    logic        take_cur;
    logic        take_ack;
    logic        fetch_needed;
    logic [31:0] target_word;
    logic        unused_target_lsb;

    assign unused_target_lsb = branch_target[0];
    assign target_word = {branch_target[31:2], 2'b00};
    assign ack_data    = mem_ack && (state == REQ_WAIT);
    assign advance     = !stall;
    assign take_cur    = advance && cur_valid;
    assign take_ack    = advance && !cur_valid && !pf_valid && ack_data;

`ifdef FETCH_PREFETCH_EN
    logic take_pf;
    logic cur_frees;
    assign take_pf      = advance && !cur_valid && pf_valid;
    assign cur_frees    = !cur_valid || (take_cur && cur_slot);
    assign fetch_needed = !pf_valid;
`else
    // Refetch only once the last slot has left the decode interface.
    assign fetch_needed = !cur_valid && !(inst_valid && stall);
`endif

    function automatic logic [15:0] half(input logic [31:0] word, input logic slot);
        return slot ? word[31:16] : word[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: every register, data included, is cleared so no X can ever reach inst/pc_out.
            state      <= REQ_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_WORD;
            fetch_addr <= RESET_WORD;
            inst       <= 16'h0000;
            inst_valid <= 1'b0;
            pc_out     <= 32'h0000_0000;
            cur_data   <= 32'h0000_0000;
            cur_word   <= 30'h0;
            cur_valid  <= 1'b0;
            cur_slot   <= 1'b0;
            skip       <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_data    <= 32'h0000_0000;
            pf_word    <= 30'h0;
            pf_valid   <= 1'b0;
`endif
        end else if (branch_taken) begin
            fetch_addr <= target_word;
            inst_valid <= 1'b0;
            cur_valid  <= 1'b0;
            skip       <= branch_target[1];
`ifdef FETCH_PREFETCH_EN
            pf_valid   <= 1'b0;
`endif
            // An outstanding read must complete before the target can be requested.
            if (state == REQ_IDLE || mem_ack) begin
                state    <= REQ_WAIT;
                mem_req  <= 1'b1;
                mem_addr <= target_word;
            end else begin
                state <= REQ_DROP;
            end
        end else begin
            case (state)
                REQ_IDLE: if (fetch_needed) begin
                    state    <= REQ_WAIT;
                    mem_req  <= 1'b1;
                    mem_addr <= fetch_addr;
                end
                REQ_WAIT: if (mem_ack) begin
                    state      <= REQ_IDLE;
                    mem_req    <= 1'b0;
                    fetch_addr <= mem_addr + 32'd4;
                end
                REQ_DROP: if (mem_ack) begin
                    state   <= REQ_IDLE;
                    mem_req <= 1'b0;
                end
                default: state <= REQ_IDLE;
            endcase

            if (take_cur) begin
                inst       <= half(cur_data, cur_slot);
                pc_out     <= {cur_word, cur_slot, 1'b0};
                inst_valid <= 1'b1;
                if (cur_slot) cur_valid <= 1'b0;
                else          cur_slot  <= 1'b1;
`ifdef FETCH_PREFETCH_EN
            end else if (take_pf) begin
                inst       <= pf_data[15:0];
                pc_out     <= {pf_word, 2'b00};
                inst_valid <= 1'b1;
                cur_data   <= pf_data;
                cur_word   <= pf_word;
                cur_slot   <= 1'b1;
                cur_valid  <= 1'b1;
                pf_valid   <= 1'b0;
`endif
            end else if (take_ack) begin
                inst       <= half(mem_rdata, skip);
                pc_out     <= {mem_addr[31:2], skip, 1'b0};
                inst_valid <= 1'b1;
                skip       <= 1'b0;
                if (!skip) begin
                    cur_data  <= mem_rdata;
                    cur_word  <= mem_addr[31:2];
                    cur_slot  <= 1'b1;
                    cur_valid <= 1'b1;
                end
            end else if (advance) begin
                inst_valid <= 1'b0;
            end

            // Data that cannot be presented this cycle is parked, oldest word in cur.
            if (ack_data && !take_ack) begin
                skip <= 1'b0;
`ifdef FETCH_PREFETCH_EN
                if (!cur_frees) begin
                    pf_data  <= mem_rdata;
                    pf_word  <= mem_addr[31:2];
                    pf_valid <= 1'b1;
                end else
`endif
                begin
                    cur_data  <= mem_rdata;
                    cur_word  <= mem_addr[31:2];
                    cur_slot  <= skip;
                    cur_valid <= 1'b1;
                end
            end
        end
    end

endmodule
